// File: rtl/register_bank_pkg.sv
// Shared defaults and the byte-merge helper for the register bank and its read ports.
package register_bank_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_ADDR_W   = 5;
    localparam int DEFAULT_NUM_READ = 2;
    localparam int DEFAULT_ZERO_REG = 1;
    localparam int DEFAULT_BYPASS   = 1;

    // A byte lane takes the new value only when its enable is set.
    function automatic logic [7:0] merge_byte(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       byte_en
    );
        return byte_en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/register_bank_read_port.sv
// One read port: picks the stored or forwarded word and registers data and busy.
module register_bank_read_port
    import register_bank_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = DEFAULT_ZERO_REG,
    parameter int BYPASS   = DEFAULT_BYPASS
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] stored_word,
    input  logic              pending_bit,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_merged,
    output logic [DATA_W-1:0] data_out,
    output logic              busy_out
);

    logic              addr_hit;
    logic              is_zero;
    logic [DATA_W-1:0] read_word;
    logic              busy_now;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        addr_hit  = reg_write && (write_address == read_addr);
        is_zero   = (ZERO_REG != 0) && (read_addr == '0);
        read_word = stored_word;
        busy_now  = pending_bit && !addr_hit;
        if ((BYPASS != 0) && addr_hit) begin
            read_word = write_merged;
        end
        if (is_zero) begin
            read_word = '0;
            busy_now  = 1'b0;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
            busy_out <= 1'b0;
        end else if (read_en) begin
            data_out <= read_word;
            busy_out <= busy_now;
        end
    end

endmodule

// File: rtl/register_bank.sv
// Multi-port register file with byte-masked writes, write forwarding and a
// pending-producer scoreboard with a registered population count.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_READ = DEFAULT_NUM_READ,
    parameter int ZERO_REG = DEFAULT_ZERO_REG,
    parameter int BYPASS   = DEFAULT_BYPASS
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_READ*ADDR_W-1:0] read_addr,
    input  logic [NUM_READ-1:0]        read_en,
    input  logic [ADDR_W-1:0]          write_address,
    input  logic [DATA_W-1:0]          write_data,
    input  logic [DATA_W/8-1:0]        write_mask,
    input  logic                       reg_write,
    input  logic                       reserve_en,
    input  logic [ADDR_W-1:0]          reserve_addr,
    output logic [NUM_READ*DATA_W-1:0] data_out,
    output logic [NUM_READ-1:0]        busy_out,
    output logic [ADDR_W:0]            pending_count
);

    localparam int NUM_REGS  = 2 ** ADDR_W;
    localparam int NUM_BYTES = DATA_W / 8;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic [ADDR_W:0]     count_next;
    logic [DATA_W-1:0]   write_merged;
    logic                write_eff;
    logic                reserve_eff;

    // Register 0 is hard-wired when ZERO_REG is set, so it never stores or goes pending.
    always_comb begin
        write_eff    = reg_write  && !((ZERO_REG != 0) && (write_address == '0));
        reserve_eff  = reserve_en && !((ZERO_REG != 0) && (reserve_addr  == '0));
        write_merged = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            write_merged[8*b +: 8] = merge_byte(regs[write_address][8*b +: 8],
                                                write_data[8*b +: 8], write_mask[b]);
        end
    end

    // Clear for the completing write first, then set for the new producer, so a
    // simultaneous reserve and write to one address leaves it pending.
    always_comb begin
        pending_next = pending;
        if (write_eff) begin
            pending_next[write_address] = 1'b0;
        end
        if (reserve_eff) begin
            pending_next[reserve_addr] = 1'b1;
        end
        count_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            count_next = count_next + (ADDR_W + 1)'(pending_next[i]);
        end
    end

    // NOTE: the storage array is cleared on reset because unwritten registers
    // must read as zero; this rules out mapping it onto a RAM macro.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            pending       <= '0;
            pending_count <= '0;
        end else begin
            if (write_eff) begin
                regs[write_address] <= write_merged;
            end
            pending       <= pending_next;
            pending_count <= count_next;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [ADDR_W-1:0] port_addr;
        assign port_addr = read_addr[p*ADDR_W +: ADDR_W];

        register_bank_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_read_port (
            .clock         (clock),
            .reset_n       (reset_n),
            .read_en       (read_en[p]),
            .read_addr     (port_addr),
            .stored_word   (regs[port_addr]),
            .pending_bit   (pending[port_addr]),
            .reg_write     (reg_write),
            .write_address (write_address),
            .write_merged  (write_merged),
            .data_out      (data_out[p*DATA_W +: DATA_W]),
            .busy_out      (busy_out[p])
        );
    end

endmodule

// File: tb/tb_register_bank.sv
// Directed, table-driven bench for register_bank at its default parameters.
module tb_register_bank;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [9:0]  read_addr;
    logic [1:0]  read_en;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [3:0]  write_mask;
    logic        reg_write;
    logic        reserve_en;
    logic [4:0]  reserve_addr;
    logic [63:0] data_out;
    logic [1:0]  busy_out;
    logic [5:0]  pending_count;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    register_bank dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .read_addr     (read_addr),
        .read_en       (read_en),
        .write_address (write_address),
        .write_data    (write_data),
        .write_mask    (write_mask),
        .reg_write     (reg_write),
        .reserve_en    (reserve_en),
        .reserve_addr  (reserve_addr),
        .data_out      (data_out),
        .busy_out      (busy_out),
        .pending_count (pending_count)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic        rsv;
        logic [4:0]  ra_rsv;
        logic [1:0]  ren;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic [5:0]  cnt;
    } vec_t;

    localparam int NUM_VECS = 17;
    vec_t vecs [NUM_VECS];

    function automatic vec_t mk(
        input logic wr, input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] wm,
        input logic rsv, input logic [4:0] ra_rsv, input logic [1:0] ren,
        input logic [4:0] ra0, input logic [4:0] ra1,
        input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] busy, input logic [5:0] cnt
    );
        vec_t v;
        v.wr = wr; v.wa = wa; v.wd = wd; v.wm = wm;
        v.rsv = rsv; v.ra_rsv = ra_rsv; v.ren = ren; v.ra0 = ra0; v.ra1 = ra1;
        v.d0 = d0; v.d1 = d1; v.busy = busy; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic idle_inputs();
        read_addr     = '0;
        read_en       = '0;
        write_address = '0;
        write_data    = '0;
        write_mask    = '0;
        reg_write     = 1'b0;
        reserve_en    = 1'b0;
        reserve_addr  = '0;
    endtask

    task automatic drive(input vec_t v);
        reg_write     = v.wr;
        write_address = v.wa;
        write_data    = v.wd;
        write_mask    = v.wm;
        reserve_en    = v.rsv;
        reserve_addr  = v.ra_rsv;
        read_en       = v.ren;
        read_addr     = {v.ra1, v.ra0};
    endtask

    initial begin
        //               wr  wa    wd            wm       rsv  rra   ren    ra0   ra1   d0            d1            busy   cnt
        vecs[0]  = mk(1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0, 2'b11, 5'd1,  5'd2,  32'h0,        32'h0,        2'b00, 6'd0);
        vecs[1]  = mk(1'b1, 5'd5,  32'hAABBCCDD, 4'hF, 1'b0, 5'd0, 2'b11, 5'd5,  5'd5,  32'hAABBCCDD, 32'hAABBCCDD, 2'b00, 6'd0);
        vecs[2]  = mk(1'b1, 5'd5,  32'h11223344, 4'h5, 1'b0, 5'd0, 2'b11, 5'd5,  5'd0,  32'hAA22CC44, 32'h0,        2'b00, 6'd0);
        vecs[3]  = mk(1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0, 2'b11, 5'd5,  5'd31, 32'hAA22CC44, 32'h0,        2'b00, 6'd0);
        vecs[4]  = mk(1'b1, 5'd7,  32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 2'b11, 5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 6'd0);
        vecs[5]  = mk(1'b1, 5'd8,  32'h12345678, 4'hF, 1'b0, 5'd0, 2'b00, 5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 6'd0);
        vecs[6]  = mk(1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd3, 2'b11, 5'd3,  5'd3,  32'h0,        32'h0,        2'b00, 6'd1);
        vecs[7]  = mk(1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0, 2'b11, 5'd3,  5'd8,  32'h0,        32'h12345678, 2'b01, 6'd1);
        vecs[8]  = mk(1'b1, 5'd3,  32'h000000A5, 4'h1, 1'b0, 5'd0, 2'b11, 5'd3,  5'd3,  32'h000000A5, 32'h000000A5, 2'b00, 6'd0);
        vecs[9]  = mk(1'b1, 5'd3,  32'h0000005A, 4'h1, 1'b1, 5'd3, 2'b11, 5'd3,  5'd3,  32'h0000005A, 32'h0000005A, 2'b00, 6'd1);
        vecs[10] = mk(1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0, 2'b11, 5'd3,  5'd4,  32'h0000005A, 32'h0,        2'b01, 6'd1);
        vecs[11] = mk(1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd3, 2'b01, 5'd3,  5'd4,  32'h0000005A, 32'h0,        2'b01, 6'd1);
        vecs[12] = mk(1'b1, 5'd10, 32'hCAFEF00D, 4'hF, 1'b0, 5'd0, 2'b10, 5'd3,  5'd10, 32'h0000005A, 32'hCAFEF00D, 2'b01, 6'd1);
        vecs[13] = mk(1'b1, 5'd0,  32'hFFFFFFFF, 4'hF, 1'b1, 5'd0, 2'b11, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd1);
        vecs[14] = mk(1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0, 2'b11, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd1);
        vecs[15] = mk(1'b1, 5'd3,  32'hFFFF0000, 4'hC, 1'b0, 5'd0, 2'b11, 5'd3,  5'd10, 32'hFFFF005A, 32'hCAFEF00D, 2'b00, 6'd0);
        vecs[16] = mk(1'b1, 5'd10, 32'h00000000, 4'h0, 1'b0, 5'd0, 2'b11, 5'd10, 5'd10, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 6'd0);

        // Reset with inputs idle; outputs must already be zero while held.
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("in_reset data", data_out, 64'h0);
        check("in_reset busy/count", {56'h0, busy_out, pending_count}, 64'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Every address reads as zero and idle right after reset.
        for (int a = 0; a < 16; a++) begin
            @(negedge clock);
            read_en   = 2'b11;
            read_addr = {5'(a + 16), 5'(a)};
            @(posedge clock);
            #1;
            check($sformatf("sweep r%0d/r%0d data", a, a + 16), data_out, 64'h0);
            check($sformatf("sweep r%0d/r%0d busy/count", a, a + 16),
                  {56'h0, busy_out, pending_count}, 64'h0);
        end

        for (int i = 0; i < NUM_VECS; i++) begin
            @(negedge clock);
            drive(vecs[i]);
            @(posedge clock);
            #1;
            check($sformatf("v%0d data0", i), {32'h0, data_out[31:0]},  {32'h0, vecs[i].d0});
            check($sformatf("v%0d data1", i), {32'h0, data_out[63:32]}, {32'h0, vecs[i].d1});
            check($sformatf("v%0d busy", i),  {62'h0, busy_out},        {62'h0, vecs[i].busy});
            check($sformatf("v%0d count", i), {58'h0, pending_count},   {58'h0, vecs[i].cnt});
        end

        // Reset pulse between edges while a write and a reserve are being driven.
        @(negedge clock);
        reg_write     = 1'b1;
        write_address = 5'd9;
        write_data    = 32'h99999999;
        write_mask    = 4'hF;
        reserve_en    = 1'b1;
        reserve_addr  = 5'd12;
        read_en       = 2'b11;
        read_addr     = {5'd9, 5'd12};
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset data immediate", data_out, 64'h0);
        check("midreset busy/count immediate", {56'h0, busy_out, pending_count}, 64'h0);
        #1;
        reset_n = 1'b1;
        idle_inputs();
        @(negedge clock);
        read_en   = 2'b11;
        read_addr = {5'd9, 5'd5};
        @(posedge clock);
        #1;
        check("after midreset r5/r9 data", data_out, 64'h0);
        check("after midreset busy/count", {56'h0, busy_out, pending_count}, 64'h0);
        @(negedge clock);
        read_addr = {5'd12, 5'd7};
        @(posedge clock);
        #1;
        check("after midreset r7/r12 data", data_out, 64'h0);
        check("after midreset r12 busy", {62'h0, busy_out}, 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
